// File: rtl/alu_regfile_pipe.sv
// Two-stage pipelined ALU with an integrated register file, result writeback,
// an immediate operand path and a stage-2 bypass so back-to-back dependent ops never stall.
module alu_regfile_pipe #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [2:0]        opcode,
   input  logic              load,
   input  logic              src_sel,
   input  logic [WIDTH-1:0]  data_in,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] rd,
   input  logic              wb_en,
   input  logic              c_in,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [WIDTH-1:0]  dbg_data,
   output logic              out_valid,
   output logic [WIDTH:0]    alu_out,
   output logic              zero
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_SUBA  = 3'd2,
      OP_OR    = 3'd3,
      OP_AND   = 3'd4,
      OP_NAND  = 3'd5,
      OP_XOR   = 3'd6,
      OP_XNOR  = 3'd7
   } op_e;

   logic [WIDTH-1:0]  regs_r [DEPTH];

   logic              s1_valid_r;
   logic [2:0]        s1_opcode_r;
   logic              s1_load_r;
   logic              s1_wb_r;
   logic              s1_cin_r;
   logic [ADDR_W-1:0] s1_rd_r;
   logic [WIDTH-1:0]  s1_a_r;
   logic [WIDTH-1:0]  s1_b_r;
   logic [WIDTH-1:0]  s1_data_r;

   logic [WIDTH:0]    result_s;
   logic              s1_writes_s;
   logic [WIDTH-1:0]  a_s;
   logic [WIDTH-1:0]  rs2_val_s;
   logic [WIDTH-1:0]  b_s;

   // Subtractions wrap in WIDTH+1 bits, so the MSB comes out as the borrow flag.
   function automatic logic [WIDTH:0] alu_fn(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             cin
   );
      logic [WIDTH:0] r;
      case (op_e'(op))
         OP_ADD:  r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
         OP_SUB:  r = {1'b0, a} - {1'b0, b};
         OP_SUBA: r = {1'b0, b} - {1'b0, a};
         OP_OR:   r = {1'b0, a | b};
         OP_AND:  r = {1'b0, a & b};
         OP_NAND: r = {1'b0, ~(a & b)};
         OP_XOR:  r = {1'b0, a ^ b};
         OP_XNOR: r = {1'b0, ~(a ^ b)};
         default: r = {(WIDTH+1){1'b0}};
      endcase
      return r;
   endfunction

   assign result_s    = s1_load_r ? {1'b0, s1_data_r}
                                  : alu_fn(s1_opcode_r, s1_a_r, s1_b_r, s1_cin_r);
   assign s1_writes_s = s1_valid_r & (s1_wb_r | s1_load_r);

   // Bypass the result being retired this edge; otherwise read architectural state.
   assign a_s       = (s1_writes_s && (s1_rd_r == rs1)) ? result_s[WIDTH-1:0] : regs_r[rs1];
   assign rs2_val_s = (s1_writes_s && (s1_rd_r == rs2)) ? result_s[WIDTH-1:0] : regs_r[rs2];
   assign b_s       = src_sel ? data_in : rs2_val_s;

   assign dbg_data  = regs_r[dbg_addr];

   // Stage 1: capture the accepted operation with its resolved operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r  <= 1'b0;
         s1_opcode_r <= 3'd0;
         s1_load_r   <= 1'b0;
         s1_wb_r     <= 1'b0;
         s1_cin_r    <= 1'b0;
         s1_rd_r     <= {ADDR_W{1'b0}};
         s1_a_r      <= {WIDTH{1'b0}};
         s1_b_r      <= {WIDTH{1'b0}};
         s1_data_r   <= {WIDTH{1'b0}};
      end else begin
         s1_valid_r  <= in_valid;
         s1_opcode_r <= opcode;
         s1_load_r   <= load;
         s1_wb_r     <= wb_en;
         s1_cin_r    <= c_in;
         s1_rd_r     <= rd;
         s1_a_r      <= a_s;
         s1_b_r      <= b_s;
         s1_data_r   <= data_in;
      end
   end

   // Stage 2: register the result; outputs hold across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         alu_out   <= {(WIDTH+1){1'b0}};
         zero      <= 1'b0;
      end else begin
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            alu_out <= result_s;
            zero    <= (result_s[WIDTH-1:0] == {WIDTH{1'b0}});
         end else begin
            alu_out <= alu_out;
            zero    <= zero;
         end
      end
   end

   // Register file write at the stage-2 edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= {WIDTH{1'b0}};
         end
      end else if (s1_writes_s) begin
         regs_r[s1_rd_r] <= result_s[WIDTH-1:0];
      end else begin
         regs_r[s1_rd_r] <= regs_r[s1_rd_r];
      end
   end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Self-checking bench for alu_regfile_pipe: directed scenarios plus random traffic
// compared against a sequential instruction-level model of the register machine.
module tb_alu_regfile_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] opcode;
   logic       load;
   logic       src_sel;
   logic [7:0] data_in;
   logic [2:0] rs1, rs2, rd;
   logic       wb_en;
   logic       c_in;
   logic [2:0] dbg_addr;
   logic [7:0] dbg_data;
   logic       out_valid;
   logic [8:0] alu_out;
   logic       zero;

   int checks   = 0;
   int failures = 0;

   logic [7:0] m [8];
   bit         exp_v;
   logic [8:0] exp_res;
   logic [8:0] last_out;
   bit         last_zero;

   alu_regfile_pipe #(.WIDTH(8), .ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode), .load(load),
      .src_sel(src_sel), .data_in(data_in), .rs1(rs1), .rs2(rs2), .rd(rd),
      .wb_en(wb_en), .c_in(c_in), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .out_valid(out_valid), .alu_out(alu_out), .zero(zero)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ref_alu(input int op, input int a, input int b, input int ci);
      int r;
      case (op)
         0: r = a + b + ci;
         1: r = a - b;
         2: r = b - a;
         3: r = a | b;
         4: r = a & b;
         5: r = 255 - (a & b);
         6: r = a ^ b;
         7: r = 255 - (a ^ b);
         default: r = 0;
      endcase
      return 9'(r & 32'h1FF);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m[i] = 8'h00;
      exp_v     = 1'b0;
      exp_res   = 9'h000;
      last_out  = 9'h000;
      last_zero = 1'b0;
   endtask

   // One cycle: drive an op, advance the model, then check the op issued one cycle earlier.
   task automatic step(input bit v, input int op, input bit ld, input bit ss, input logic [7:0] d,
                       input int r1, input int r2, input int rdd, input bit wb, input bit ci);
      int a, b;
      logic [8:0] res;
      in_valid = v; opcode = 3'(op); load = ld; src_sel = ss; data_in = d;
      rs1 = 3'(r1); rs2 = 3'(r2); rd = 3'(rdd); wb_en = wb; c_in = ci;
      a   = int'(m[r1]);
      b   = ss ? int'(d) : int'(m[r2]);
      res = ld ? {1'b0, d} : ref_alu(op, a, b, int'(ci));
      if (v && (wb || ld)) m[rdd] = res[7:0];
      @(posedge clk); #1;
      checks++;
      if (exp_v) begin
         if (out_valid !== 1'b1 || alu_out !== exp_res || zero !== (exp_res[7:0] == 8'h00)) begin
            failures++;
            $display("FAIL result: got v=%b out=%h z=%b, want v=1 out=%h z=%b",
                     out_valid, alu_out, zero, exp_res, (exp_res[7:0] == 8'h00));
         end
         last_out  = exp_res;
         last_zero = (exp_res[7:0] == 8'h00);
      end else begin
         if (out_valid !== 1'b0 || alu_out !== last_out || zero !== last_zero) begin
            failures++;
            $display("FAIL hold: got v=%b out=%h z=%b, want v=0 out=%h z=%b",
                     out_valid, alu_out, zero, last_out, last_zero);
         end
      end
      exp_v   = v;
      exp_res = res;
   endtask

   task automatic op_load(input int rdd, input logic [7:0] d);
      step(1'b1, 0, 1'b1, 1'b0, d, 0, 0, rdd, 1'b0, 1'b0);
   endtask

   task automatic op_alu(input int op, input int rdd, input int r1, input int r2, input bit wb, input bit ci);
      step(1'b1, op, 1'b0, 1'b0, 8'h00, r1, r2, rdd, wb, ci);
   endtask

   task automatic bubble();
      step(1'b0, 0, 1'b0, 1'b0, 8'h00, 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; opcode = 3'd0; load = 1'b0; src_sel = 1'b0;
      data_in = 8'h00; rs1 = 3'd0; rs2 = 3'd0; rd = 3'd0; wb_en = 1'b0; c_in = 1'b0;
      dbg_addr = 3'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || alu_out !== 9'h000 || zero !== 1'b0) begin
         failures++;
         $display("FAIL reset_out: got v=%b out=%h z=%b, want 0/000/0", out_valid, alu_out, zero);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         checks++;
         if (dbg_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_reg r%0d: got %h want 00", i, dbg_data);
         end
      end
   endtask

   task automatic test_load_add();
      op_load(1, 8'h80);
      op_load(2, 8'h01);
      op_alu(0, 3, 1, 2, 1'b1, 1'b1);
      bubble();
      checks++;
      if (alu_out !== 9'h082 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL load_add: got v=%b out=%h want v=1 out=082", out_valid, alu_out);
      end
      dbg_addr = 3'd3; #1;
      checks++;
      if (dbg_data !== 8'h82) begin
         failures++;
         $display("FAIL load_add_r3: got %h want 82", dbg_data);
      end
   endtask

   task automatic test_forwarding();
      op_load(1, 8'hFF);
      op_alu(0, 2, 1, 1, 1'b1, 1'b0);
      bubble();
      checks++;
      if (alu_out !== 9'h1FE) begin
         failures++;
         $display("FAIL fwd: got %h want 1fe", alu_out);
      end
      dbg_addr = 3'd2; #1;
      checks++;
      if (dbg_data !== 8'hFE) begin
         failures++;
         $display("FAIL fwd_r2: got %h want fe", dbg_data);
      end
   endtask

   task automatic test_subtract();
      op_load(1, 8'h05);
      op_load(2, 8'h07);
      op_alu(1, 3, 1, 2, 1'b0, 1'b1);
      op_alu(2, 3, 1, 2, 1'b0, 1'b1);
      checks++;
      if (alu_out !== 9'h1FE) begin
         failures++;
         $display("FAIL sub: got %h want 1fe", alu_out);
      end
      step(1'b1, 1, 1'b0, 1'b1, 8'h05, 1, 2, 3, 1'b0, 1'b0);
      checks++;
      if (alu_out !== 9'h002) begin
         failures++;
         $display("FAIL sub_a: got %h want 002", alu_out);
      end
      bubble();
      checks++;
      if (alu_out !== 9'h000 || zero !== 1'b1) begin
         failures++;
         $display("FAIL sub_imm: got %h z=%b want 000 z=1", alu_out, zero);
      end
   endtask

   task automatic test_logic();
      logic [8:0] want [6];
      want[0] = 9'h0AF; want[1] = 9'h005; want[2] = 9'h0FA;
      want[3] = 9'h0AA; want[4] = 9'h055; want[5] = 9'h000;
      op_load(1, 8'hA5);
      op_load(2, 8'h0F);
      op_alu(3, 4, 1, 2, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) op_alu(4 + i, 4, 1, 2, 1'b0, 1'b1);
         else if (i == 4) op_alu(6, 4, 1, 1, 1'b0, 1'b0);
         else bubble();
         checks++;
         if (alu_out !== want[i] || zero !== (want[i][7:0] == 8'h00)) begin
            failures++;
            $display("FAIL logic_%0d: got %h z=%b want %h", i, alu_out, zero, want[i]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      op_load(1, 8'h03);
      op_load(2, 8'h04);
      bubble();
      in_valid = 1'b1; opcode = 3'd0; load = 1'b0; src_sel = 1'b0;
      rs1 = 3'd1; rs2 = 3'd2; rd = 3'd4; wb_en = 1'b1; c_in = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      model_reset();
      checks++;
      if (out_valid !== 1'b0 || alu_out !== 9'h000) begin
         failures++;
         $display("FAIL midreset_out: got v=%b out=%h want 0/000", out_valid, alu_out);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      dbg_addr = 3'd4; #1;
      checks++;
      if (dbg_data !== 8'h00 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_r4: got r4=%h v=%b want 00 v=0", dbg_data, out_valid);
      end
      step(1'b0, 0, 1'b1, 1'b0, 8'h55, 0, 0, 4, 1'b1, 1'b0);
      bubble();
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         checks++;
         if (dbg_data !== 8'h00) begin
            failures++;
            $display("FAIL bubble_write r%0d: got %h want 00", i, dbg_data);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 9) != 0), int'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0),
              $urandom_range(0, 1), 8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 1));
      end
      bubble();
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         checks++;
         if (dbg_data !== m[i]) begin
            failures++;
            $display("FAIL random_reg r%0d: got %h want %h", i, dbg_data, m[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_add();
      test_forwarding();
      test_subtract();
      test_logic();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_regfile_pipe.md
# alu_regfile_pipe

Parametrised two-stage pipelined ALU with an integrated register file. It replaces the fixed 8-bit, 8-entry ALU/register-file pair and adds configurable width and depth, ALU-result writeback into the register file, an immediate operand path, a valid handshake and read-after-write forwarding. It sits between the operand sequencer and the result consumer.

## Interface
- WIDTH, 8, datapath width in bits (≥ 2)
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operation present this cycle
- opcode  in  3  operation select (see Operation)
- load  in  1  1 = write data_in to rd, ignoring the ALU
- src_sel  in  1  operand b: 0 = register rs2, 1 = data_in
- data_in  in  WIDTH  immediate / load data
- rs1, rs2, rd  in  ADDR_W  source and destination register addresses
- wb_en  in  1  write the result to rd
- c_in  in  1  carry-in, used by add only
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  WIDTH  combinational register read of dbg_addr (architectural state, no bypass)
- out_valid  out  1  alu_out/zero hold a new result
- alu_out  out  WIDTH+1  result; MSB is carry/borrow
- zero  out  1  alu_out[WIDTH-1:0] == 0

## Operation
- Every cycle an operation can be accepted. There is no back-pressure, and in_valid=0 inserts a bubble.
- Operands: a = reg[rs1]; b = src_sel ? data_in : reg[rs2].
- Opcodes use {1'b0,a}/{1'b0,b} extended to WIDTH+1 bits:
  - 0 add = a + b + c_in
  - 1 sub = a − b; MSB=1 on borrow
  - 2 sub_a = b − a
  - 3 or = a | b
  - 4 and = a & b
  - 5 nand = ~(a & b)
  - 6 xor = a ^ b
  - 7 xnor = ~(a ^ b)
- Logic ops force MSB=0. c_in is ignored except by add.
- load=1 overrides the opcode: result = {1'b0, data_in}.
- Writeback: if wb_en=1 or load=1, result[WIDTH-1:0] is written to reg[rd] at the stage-2 edge. Register 0 is an ordinary register.
- Forwarding: operand reads see the result of every earlier accepted operation, including the one immediately ahead in stage 2. The priority order is:
  - stage-2 result when its rd matches and it writes;
  - otherwise the register file.
- src_sel=1 with load=0 is legal (ALU op with immediate).

## Timing
- Stage 1 captures the operation on edge N: in_valid, opcode, flags and rd, plus forwarded a/b values.
- Stage 2 on edge N+1:
  - computes the result;
  - registers alu_out and zero;
  - sets out_valid;
  - performs the register write.
- Latency is 2 edges. An operation presented in cycle N appears on alu_out with out_valid=1 during cycle N+1, after edge N+1.
- Throughput is one operation per cycle. out_valid mirrors the valid bit of the issuing cycle.
- When out_valid=0, alu_out and zero hold their previous values.
- Back-to-back RAW needs no stall:
  - Op B, issued the cycle after op A, reads A's result through the stage-2 bypass.
  - Op B issued two or more cycles after A reads the written register.
- A bubble (in_valid=0) never writes a register, even if wb_en=1.
- Reset (rst_n=0, asynchronous):
  - all registers = 0; both valid bits = 0;
  - alu_out = 0; zero = 0; out_valid = 0.
- Reset mid-operation discards in-flight operations with no register write. The first valid input is sampled on the first rising edge with rst_n=1.
- dbg_data shows the updated value in the cycle after a write edge.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, release, then sweep dbg_addr 0..7 -> dbg_data=0 everywhere, out_valid=0, alu_out=0.
- Load then add: load r1=0x80, load r2=0x01 (consecutive), then add rd=r3, rs1=r1, rs2=r2, c_in=1, wb_en=1 -> alu_out=0x082 two edges after issue; later dbg r3=0x82.
- Forwarding: load r1=0xFF, next cycle add rd=r2, rs1=r1, rs2=r1, c_in=0 -> alu_out=0x1FE; dbg r2=0xFE.
- Subtract/borrow: r1=0x05, r2=0x07:
  - sub -> 0x1FE;
  - sub_a -> 0x002;
  - sub with src_sel=1, data_in=0x05 -> 0x000 and zero=1.
- Logic sweep: r1=0xA5, r2=0x0F:
  - or -> 0x0AF
  - and -> 0x005
  - nand -> 0x0FA
  - xor -> 0x0AA
  - xnor -> 0x055
  - xor r1,r1 -> 0x000 with zero=1
- Reset mid-flight: issue add with wb_en=1 to r4, then assert rst_n low before the stage-2 edge -> r4 stays 0, out_valid=0; a bubble with wb_en=1 also leaves registers unchanged.
